// File: rtl/prt_frame_writer.sv
// prt_frame_writer: allocates a PRT slot per received frame, streams its bytes in, then finishes or invalidates it.
// Optional PRT_WRITER_FCS_STRIP_EN holds back the trailing 4-byte FCS so it is never written.
module prt_frame_writer #(
   parameter int INDEX_SIZE = 1,
   parameter int DATA_SIZE  = 8,
   parameter int FRAME_SIZE = 1518,
   parameter int MIN_FRAME  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [DATA_SIZE-1:0]  rx_data,
   input  logic                  rx_last,
   input  logic                  rx_error,
   output logic                  rx_ready,
   input  logic                  prt_slot_free,
   output logic                  prt_start_req,
   input  logic                  prt_start_ack,
   input  logic [INDEX_SIZE-1:0] prt_start_slot,
   output logic                  prt_wr_en,
   output logic [DATA_SIZE-1:0]  prt_wr_data,
   output logic                  prt_finish,
   output logic                  prt_invalidate,
   output logic [INDEX_SIZE-1:0] prt_inv_slot,
   output logic                  desc_valid,
   output logic [INDEX_SIZE-1:0] desc_slot,
   output logic [15:0]           desc_len,
   input  logic                  desc_ready,
   output logic [15:0]           drop_count
);
   typedef enum logic [2:0] {IDLE, ALLOC, STREAM, RUNT, FINISH, POST, DISCARD} state_t;
   state_t                r_state;
   logic [15:0]           r_len;
   logic [INDEX_SIZE-1:0] r_slot;
   logic                  w_acc;
   logic                  w_push;
   logic [DATA_SIZE-1:0]  w_byte;
   logic [15:0]           w_len_nx;
   logic [15:0]           w_len_fin;
   logic [15:0]           w_drop_nx;
   assign rx_ready  = (r_state == STREAM) || (r_state == DISCARD);
   assign w_acc     = rx_valid && rx_ready;
   assign w_len_nx  = r_len + 16'd1;
   assign w_drop_nx = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
`ifdef PRT_WRITER_FCS_STRIP_EN
   logic [3:0][DATA_SIZE-1:0] r_dly;
   // A byte is written only once four newer bytes have arrived behind it.
   always_ff @(posedge clk)
      if (reset || prt_invalidate || r_state == FINISH) r_dly <= '0;
      else if (r_state == STREAM && w_acc) r_dly <= {r_dly[2:0], rx_data};
   assign w_push    = r_len >= 16'd4;
   assign w_byte    = r_dly[3];
   assign w_len_fin = r_len - 16'd4;
`else
   assign w_push    = 1'b1;
   assign w_byte    = rx_data;
   assign w_len_fin = r_len;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_len          <= '0;
         r_slot         <= '0;
         prt_start_req  <= 1'b0;
         prt_wr_en      <= 1'b0;
         prt_wr_data    <= '0;
         prt_finish     <= 1'b0;
         prt_invalidate <= 1'b0;
         prt_inv_slot   <= '0;
         desc_valid     <= 1'b0;
         desc_slot      <= '0;
         desc_len       <= '0;
         drop_count     <= '0;
      end else begin
         prt_wr_en      <= 1'b0;
         prt_finish     <= 1'b0;
         prt_invalidate <= 1'b0;
         case (r_state)
            IDLE: if (rx_valid && prt_slot_free) begin
               prt_start_req <= 1'b1;
               r_state       <= ALLOC;
            end
            ALLOC: if (prt_start_ack) begin
               prt_start_req <= 1'b0;
               r_slot        <= prt_start_slot;
               r_len         <= '0;
               r_state       <= STREAM;
            end
            STREAM: if (w_acc) begin
               r_len <= w_len_nx;
               if (rx_error || r_len == 16'(FRAME_SIZE)) begin
                  prt_invalidate <= 1'b1;
                  prt_inv_slot   <= r_slot;
                  drop_count     <= w_drop_nx;
                  r_state        <= rx_last ? IDLE : DISCARD;
               end else begin
                  prt_wr_en   <= w_push;
                  prt_wr_data <= w_byte;
                  if (rx_last) r_state <= (w_len_nx < 16'(MIN_FRAME)) ? RUNT : FINISH;
               end
            end
            // Runt invalidate trails its final write by one cycle.
            RUNT: begin
               prt_invalidate <= 1'b1;
               prt_inv_slot   <= r_slot;
               drop_count     <= w_drop_nx;
               r_state        <= IDLE;
            end
            FINISH: begin
               prt_finish <= 1'b1;
               desc_valid <= 1'b1;
               desc_slot  <= r_slot;
               desc_len   <= w_len_fin;
               r_state    <= POST;
            end
            POST: if (desc_ready) begin
               desc_valid <= 1'b0;
               r_state    <= IDLE;
            end
            DISCARD: if (w_acc && rx_last) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
